// File: rtl/bnn_cmd_loader.sv
`default_nettype none
// ============================================================================
// Module   : bnn_cmd_loader
// Purpose  : Frames opcode/payload/trailer byte stream into BNN input,
//            weight and bias registers with framing-error and timeout abort.
// Revision : 1.0
// ============================================================================
module bnn_cmd_loader #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  inputs_q,
    output logic [15:0] weights_q,
    output logic [15:0] bias_q,
    output logic        load_done,
    output logic [1:0]  load_sel,
    output logic        err,
    output logic        busy
);

    localparam int c_IDLE_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PAYLOAD = 2'd1;
    localparam logic [1:0] c_ST_TRAILER = 2'd2;

    localparam logic [1:0] c_SEL_IN = 2'b01;
    localparam logic [1:0] c_SEL_W  = 2'b10;
    localparam logic [1:0] c_SEL_B  = 2'b11;

    logic [1:0]          r_state;
    logic [1:0]          r_tgt;
    logic [1:0]          r_cnt;
    logic [15:0]         r_shadow;
    logic [c_IDLE_W-1:0] r_idle;
    logic [7:0]          r_inputs_q;
    logic [15:0]         r_weights_q;
    logic [15:0]         r_bias_q;
    logic                r_done;
    logic [1:0]          r_sel;
    logic                r_err;
    logic                r_busy;

    logic                w_is_op;
    logic [1:0]          w_op_tgt;
    logic [1:0]          w_need;
    logic                w_timeout;

    // Opcode low bits map directly onto the load_sel encoding.
    assign w_is_op   = (rx_byte == 8'hB1) || (rx_byte == 8'hB2) || (rx_byte == 8'hB3);
    assign w_op_tgt  = rx_byte[1:0];
    assign w_need    = (r_tgt == c_SEL_IN) ? 2'd1 : 2'd2;
    assign w_timeout = !rx_valid && (r_idle == c_IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_tgt       <= 2'b00;
            r_cnt       <= 2'd0;
            r_shadow    <= 16'h0000;
            r_idle      <= '0;
            r_inputs_q  <= 8'h00;
            r_weights_q <= 16'h0000;
            r_bias_q    <= 16'h0000;
            r_done      <= 1'b0;
            r_sel       <= 2'b00;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (rx_valid) begin
                        if (w_is_op) begin
                            r_tgt    <= w_op_tgt;
                            r_cnt    <= 2'd0;
                            r_shadow <= 16'h0000;
                            r_idle   <= '0;
                            r_state  <= c_ST_PAYLOAD;
                            r_busy   <= 1'b1;
                        end else if (rx_byte != 8'h00) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_ST_PAYLOAD, c_ST_TRAILER: begin
                    if (rx_valid) begin
                        r_idle <= '0;
                        if (r_state == c_ST_PAYLOAD) begin
                            r_shadow <= {r_shadow[7:0], rx_byte};
                            r_cnt    <= r_cnt + 2'd1;
                            if ((r_cnt + 2'd1) == w_need) begin
                                r_state <= c_ST_TRAILER;
                            end
                        end else begin
                            // Non-zero trailer aborts; it is never reused as an opcode.
                            if (rx_byte == 8'h00) begin
                                case (r_tgt)
                                    c_SEL_IN: r_inputs_q  <= r_shadow[7:0];
                                    c_SEL_W:  r_weights_q <= r_shadow;
                                    c_SEL_B:  r_bias_q    <= r_shadow;
                                    default:  ;
                                endcase
                                r_sel  <= r_tgt;
                                r_done <= 1'b1;
                            end else begin
                                r_err <= 1'b1;
                            end
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign inputs_q  = r_inputs_q;
    assign weights_q = r_weights_q;
    assign bias_q    = r_bias_q;
    assign load_done = r_done;
    assign load_sel  = r_sel;
    assign err       = r_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bnn_cmd_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bnn_cmd_loader
// Purpose  : Directed frames for bnn_cmd_loader, checked every cycle against
//            a frame-level model plus literal expectations.
// Revision : 1.0
// ============================================================================
module tb_bnn_cmd_loader;

    localparam int c_TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  inputs_q;
    logic [15:0] weights_q;
    logic [15:0] bias_q;
    logic        load_done;
    logic [1:0]  load_sel;
    logic        err;
    logic        busy;

    bnn_cmd_loader #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .inputs_q  (inputs_q),
        .weights_q (weights_q),
        .bias_q    (bias_q),
        .load_done (load_done),
        .load_sel  (load_sel),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: tracks the open frame as an opcode plus a byte queue.
    bit         m_ok = 1'b0;
    bit         m_open;
    logic [7:0] m_op;
    logic [7:0] m_pay[$];
    int         m_idle;
    logic [7:0]  e_in;
    logic [15:0] e_w, e_b;
    logic [1:0]  e_sel;
    logic        e_done, e_err;

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1'b1; m_open = 1'b0; m_pay.delete(); m_idle = 0;
            e_in = 0; e_w = 0; e_b = 0; e_sel = 0; e_done = 0; e_err = 0;
        end else if (m_ok) begin
            e_done = 0; e_err = 0;
            if (!m_open) begin
                if (rx_valid) begin
                    if (rx_byte inside {8'hB1, 8'hB2, 8'hB3}) begin
                        m_open = 1'b1; m_op = rx_byte; m_pay.delete(); m_idle = 0;
                    end else if (rx_byte != 8'h00) begin
                        e_err = 1;
                    end
                end
            end else if (rx_valid) begin
                int need;
                m_idle = 0;
                need = (m_op == 8'hB1) ? 1 : 2;
                if (m_pay.size() < need) begin
                    m_pay.push_back(rx_byte);
                end else begin
                    if (rx_byte == 8'h00) begin
                        if (m_op == 8'hB1)      e_in = m_pay[0];
                        else if (m_op == 8'hB2) e_w  = {m_pay[0], m_pay[1]};
                        else                    e_b  = {m_pay[0], m_pay[1]};
                        e_sel  = (m_op == 8'hB1) ? 2'b01 : (m_op == 8'hB2) ? 2'b10 : 2'b11;
                        e_done = 1;
                    end else begin
                        e_err = 1;
                    end
                    m_open = 1'b0;
                end
            end else begin
                m_idle++;
                if (m_idle == c_TIMEOUT) begin
                    e_err = 1; m_open = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("inputs_q",  32'(inputs_q),  32'(e_in));
            check("weights_q", 32'(weights_q), 32'(e_w));
            check("bias_q",    32'(bias_q),    32'(e_b));
            check("load_sel",  32'(load_sel),  32'(e_sel));
            check("load_done", 32'(load_done), 32'(e_done));
            check("err",       32'(err),       32'(e_err));
            check("busy",      32'(busy),      32'(m_open));
            check("err_and_done_exclusive", 32'(err & load_done), 32'd0);
        end
        if (load_done === 1'b1) n_done++;
    end

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i]);
    endtask

    initial begin
        int d0;
        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_inputs", 32'(inputs_q), 32'h0);
        check("reset_sel",    32'(load_sel), 32'h0);
        check("reset_busy",   32'(busy),     32'h0);

        // Single-byte inputs frame
        send_seq('{8'hB1, 8'h0E, 8'h00});
        check("030_done",    32'(load_done), 32'h1);
        check("030_inputs",  32'(inputs_q),  32'h0E);
        check("030_sel",     32'(load_sel),  32'h1);
        check("030_weights", 32'(weights_q), 32'h0);
        check("030_bias",    32'(bias_q),    32'h0);
        @(negedge clk);
        check("030_done_one_cycle", 32'(load_done), 32'h0);

        // Weights frame with a 0x00 payload byte, then bias
        d0 = n_done;
        send_seq('{8'hB2, 8'h00, 8'hDE, 8'h00});
        check("031_weights", 32'(weights_q), 32'h00DE);
        send_seq('{8'hB3, 8'h12, 8'h34, 8'h00});
        check("031_bias",    32'(bias_q),    32'h1234);
        check("031_sel",     32'(load_sel),  32'h3);
        check("031_inputs_held", 32'(inputs_q), 32'h0E);
        @(negedge clk);
        check("031_done_count", 32'(n_done - d0), 32'd2);

        // Opcode-valued payload bytes are data
        send_seq('{8'hB2, 8'hB1, 8'hB3, 8'h00});
        check("payload_opcodes", 32'(weights_q), 32'hB1B3);

        // Bad trailer
        send_seq('{8'hB2, 8'hAA, 8'hBB, 8'h55});
        check("032_err",     32'(err),       32'h1);
        check("032_busy",    32'(busy),      32'h0);
        check("032_weights", 32'(weights_q), 32'hB1B3);
        send_seq('{8'hB1, 8'h07, 8'h00});
        check("032_inputs",  32'(inputs_q),  32'h07);

        // Unknown and filler bytes in IDLE
        send(8'h5A);
        check("033_err",  32'(err),  32'h1);
        check("033_busy", 32'(busy), 32'h0);
        send(8'h00);
        check("033_filler_err", 32'(err), 32'h0);

        // Timeout abort
        send_seq('{8'hB3, 8'h01});
        repeat (c_TIMEOUT - 1) @(negedge clk);
        check("034_no_early_err", 32'(err),  32'h0);
        check("034_busy_before",  32'(busy), 32'h1);
        @(negedge clk);
        check("034_err",  32'(err),    32'h1);
        check("034_busy", 32'(busy),   32'h0);
        check("034_bias", 32'(bias_q), 32'h1234);

        // Reset mid-frame, with a valid opcode presented during reset
        d0 = n_done;
        send_seq('{8'hB2, 8'h11});
        rst = 1'b1; rx_valid = 1'b1; rx_byte = 8'hB1;
        @(negedge clk);
        rst = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        check("035_busy_after_rst", 32'(busy),      32'h0);
        check("035_err_after_rst",  32'(err),       32'h0);
        check("035_weights_rst",    32'(weights_q), 32'h0);
        send(8'h22);
        check("035_err_unknown", 32'(err), 32'h1);
        send(8'h00);
        check("035_no_err", 32'(err),       32'h0);
        check("035_no_done_count", 32'(n_done - d0), 32'd0);
        check("035_weights", 32'(weights_q), 32'h0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/bnn_cmd_loader.md
BNN_CMD_LOADER -- requirements
Module: bnn_cmd_loader

Interface
REQ-001 Parameter TIMEOUT, default 255: idle cycles allowed between bytes of one frame before abort.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rx_byte  input  8  command/payload byte from the SPI byte stage.
REQ-005 rx_valid  input  1  rx_byte valid for this cycle; every valid byte is accepted, no backpressure.
REQ-006 inputs_q  output  8  committed BNN input vector.
REQ-007 weights_q  output  16  committed weight word.
REQ-008 bias_q  output  16  committed bias word.
REQ-009 load_done  output  1  one-cycle pulse when a frame commits.
REQ-010 load_sel  output  2  target of the last commit: 01 inputs, 10 weights, 11 bias; 00 until the first commit.
REQ-011 err  output  1  one-cycle pulse on any framing error.
REQ-012 busy  output  1  high while the FSM is outside IDLE.

Function
REQ-013 Frame = opcode byte, N payload bytes, then trailer 0x00; opcodes: 0xB1 -> inputs (N=1), 0xB2 -> weights (N=2), 0xB3 -> bias (N=2).
REQ-014 FSM states: IDLE, PAYLOAD, TRAILER; only cycles with rx_valid=1 advance it.
REQ-015 IDLE: valid 0xB1/0xB2/0xB3 latches the target, clears the byte counter and the shadow register, and moves to PAYLOAD.
REQ-016 IDLE: valid 0x00 is filler, ignored, no err.
REQ-017 IDLE: any other valid byte is dropped, err pulses, FSM stays in IDLE.
REQ-018 PAYLOAD: each valid byte shifts into the 16-bit shadow register MSB-first (first byte -> [15:8]; for 0xB1 the single byte -> [7:0]), and the counter increments.
REQ-019 PAYLOAD: the counter reaching N moves the FSM to TRAILER; payload bytes are data, including 0x00 and 0xB1-0xB3.
REQ-020 TRAILER: valid 0x00 copies the shadow to the target output register and moves to IDLE.
REQ-021 Commit timing: output register, load_sel and load_done all update in the cycle after the trailer byte; load_done lasts exactly one cycle.
REQ-022 TRAILER: a valid non-zero byte discards the shadow, leaves all output registers unchanged, pulses err, and moves to IDLE; the byte is not reinterpreted as an opcode.
REQ-023 Timeout: an 8-bit-or-wider idle counter runs in PAYLOAD/TRAILER, clears on each valid byte, and on reaching TIMEOUT aborts to IDLE with an err pulse and no commit.
REQ-024 busy = 1 in PAYLOAD and TRAILER, 0 in IDLE; it is registered with the state.
REQ-025 err and load_done are never high in the same cycle.
REQ-026 Unselected output registers hold their value across any frame.

Reset
REQ-027 rst=1 at a clock edge forces IDLE and zeroes the counters and shadow.
REQ-028 rst=1 at a clock edge sets inputs_q=0, weights_q=0, bias_q=0, load_sel=00, load_done=0, err=0, busy=0.
REQ-029 rst mid-frame discards the partial frame without a commit or err; rst has priority over rx_valid in the same cycle.

Verification
REQ-030 Bytes B1, 0E, 00 -> inputs_q=0x0E, load_sel=01, load_done one pulse the cycle after 00; weights_q and bias_q stay 0.
REQ-031 Bytes B2, 00, DE, 00 then B3, 12, 34, 00 -> weights_q=0x00DE, then bias_q=0x1234, load_sel=11, two load_done pulses total.
REQ-032 Bytes B2, AA, BB, 55 -> err pulse, weights_q unchanged, busy=0 afterwards; a following B1, 07, 00 commits inputs_q=0x07.
REQ-033 Byte 5A in IDLE -> err pulse, busy stays 0; byte 00 in IDLE -> no err.
REQ-034 B3, 01 then no rx_valid for TIMEOUT cycles -> err pulse, FSM back in IDLE, bias_q unchanged.
REQ-035 B2, 11, then rst=1 for one cycle, then 22, 00 -> no commit and no err; the 22 byte raises err as an unknown opcode.
